// File: rtl/freq_meter_scheduler.sv
// Scheduler that time-multiplexes one frequency meter across CH_NUM test clocks,
// settling the mux and discarding partial readouts before capturing one result
// per enabled channel into a readable result table.
module freq_meter_scheduler #(
  parameter int unsigned CH_NUM         = 4,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned DISCARD_NUM    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 262144,
  localparam int unsigned SEL_W         = $clog2(CH_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic [CH_NUM-1:0] chan_mask,
  input  logic              meas_valid,
  input  logic [31:0]       meas_value,
  output logic [SEL_W-1:0]  mux_sel,
  output logic              meter_ena,
  output logic              busy,
  output logic              res_we,
  output logic [SEL_W-1:0]  res_chan,
  output logic [31:0]       res_value,
  output logic [CH_NUM-1:0] dead,
  output logic              scan_done,
  input  logic [SEL_W-1:0]  rd_chan,
  output logic [31:0]       rd_value
);

  localparam int unsigned PTR_W = SEL_W + 1;
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned DIS_W = (DISCARD_NUM > 0) ? $clog2(DISCARD_NUM + 1) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, SEL, SETTLE, DISCARD, MEASURE, STORE, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CH_NUM-1:0]   mask_q, mask_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [SEL_W-1:0]    ch_q, ch_d;
  logic [SEL_W-1:0]    mux_sel_q, mux_sel_d;
  logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
  logic [DIS_W-1:0]    dis_cnt_q, dis_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                meter_ena_q, meter_ena_d;
  logic                busy_q, busy_d;
  logic                res_we_q, res_we_d;
  logic [SEL_W-1:0]    res_chan_q, res_chan_d;
  logic [31:0]         res_value_q, res_value_d;
  logic [CH_NUM-1:0]   dead_q, dead_d;
  logic                scan_done_q, scan_done_d;
  logic                after_done_q, after_done_d;
  logic [31:0]         rd_value_q;
  logic [31:0]         tbl_q [CH_NUM];
  logic [31:0]         tbl_d [CH_NUM];

  logic                found;
  logic [SEL_W-1:0]    nxt_idx;
  logic                tmo_hit;
  logic                cap_ok;
  logic                cap_tmo;
  logic [31:0]         cap_val;

  // Lowest enabled channel at or above the scan pointer
  always_comb begin
    found   = 1'b0;
    nxt_idx = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (mask_q[i] && (PTR_W'(i) >= ptr_q)) begin
        found   = 1'b1;
        nxt_idx = SEL_W'(i);
      end
    end
  end

  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Next-state and registered-output logic; a capture (valid or timeout) jumps to STORE
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    ptr_d        = ptr_q;
    ch_d         = ch_q;
    mux_sel_d    = mux_sel_q;
    set_cnt_d    = set_cnt_q;
    dis_cnt_d    = dis_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    res_we_d     = 1'b0;
    res_chan_d   = res_chan_q;
    res_value_d  = res_value_q;
    dead_d       = dead_q;
    scan_done_d  = 1'b0;
    after_done_d = 1'b0;
    tbl_d        = tbl_q;
    cap_ok       = 1'b0;
    cap_tmo      = 1'b0;
    cap_val      = '0;

    case (state_q)
      IDLE: begin
        if (start || (continuous && after_done_q)) begin
          mask_d  = chan_mask;
          ptr_d   = '0;
          state_d = SEL;
        end
      end
      SEL: begin
        if (found) begin
          mux_sel_d = nxt_idx;
          ch_d      = nxt_idx;
          set_cnt_d = '0;
          state_d   = SETTLE;
        end else begin
          scan_done_d = 1'b1;
          state_d     = DONE;
        end
      end
      SETTLE: begin
        if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          tmo_cnt_d = '0;
          dis_cnt_d = '0;
          state_d   = (DISCARD_NUM > 0) ? DISCARD : MEASURE;
        end else begin
          set_cnt_d = set_cnt_q + SET_W'(1);
        end
      end
      DISCARD: begin
        if (meas_valid) begin
          tmo_cnt_d = '0;
          if (dis_cnt_q == DIS_W'(DISCARD_NUM - 1)) begin
            state_d = MEASURE;
          end else begin
            dis_cnt_d = dis_cnt_q + DIS_W'(1);
          end
        end else if (tmo_hit) begin
          cap_tmo = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      MEASURE: begin
        if (meas_valid) begin
          cap_ok = 1'b1;
        end else if (tmo_hit) begin
          cap_tmo = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      STORE: begin
        state_d = SEL;
      end
      DONE: begin
        after_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (cap_ok || cap_tmo) begin
      cap_val        = cap_ok ? meas_value : 32'd0;
      tbl_d[ch_q]    = cap_val;
      res_we_d       = 1'b1;
      res_chan_d     = ch_q;
      res_value_d    = cap_val;
      dead_d[ch_q]   = cap_tmo;
      ptr_d          = PTR_W'(ch_q) + PTR_W'(1);
      state_d        = STORE;
    end
  end

  assign busy_d      = (state_d != IDLE) && (state_d != DONE);
  assign meter_ena_d = (state_d == DISCARD) || (state_d == MEASURE);

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      ptr_q        <= '0;
      ch_q         <= '0;
      mux_sel_q    <= '0;
      set_cnt_q    <= '0;
      dis_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      meter_ena_q  <= 1'b0;
      busy_q       <= 1'b0;
      res_we_q     <= 1'b0;
      res_chan_q   <= '0;
      res_value_q  <= '0;
      dead_q       <= '0;
      scan_done_q  <= 1'b0;
      after_done_q <= 1'b0;
      tbl_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      ptr_q        <= ptr_d;
      ch_q         <= ch_d;
      mux_sel_q    <= mux_sel_d;
      set_cnt_q    <= set_cnt_d;
      dis_cnt_q    <= dis_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      meter_ena_q  <= meter_ena_d;
      busy_q       <= busy_d;
      res_we_q     <= res_we_d;
      res_chan_q   <= res_chan_d;
      res_value_q  <= res_value_d;
      dead_q       <= dead_d;
      scan_done_q  <= scan_done_d;
      after_done_q <= after_done_d;
      tbl_q        <= tbl_d;
    end
  end

  // Table readback, independent of the scan; a same-cycle write is seen next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_value_q <= '0;
    end else begin
      rd_value_q <= tbl_q[rd_chan];
    end
  end

  assign mux_sel   = mux_sel_q;
  assign meter_ena = meter_ena_q;
  assign busy      = busy_q;
  assign res_we    = res_we_q;
  assign res_chan  = res_chan_q;
  assign res_value = res_value_q;
  assign dead      = dead_q;
  assign scan_done = scan_done_q;
  assign rd_value  = rd_value_q;

endmodule

// File: tb/tb_freq_meter_scheduler.sv
// Directed bench for freq_meter_scheduler with a small behavioural meter model.
module tb_freq_meter_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        continuous;
  logic [3:0]  chan_mask;
  logic        meas_valid;
  logic [31:0] meas_value;
  logic [1:0]  mux_sel;
  logic        meter_ena;
  logic        busy;
  logic        res_we;
  logic [1:0]  res_chan;
  logic [31:0] res_value;
  logic [3:0]  dead;
  logic        scan_done;
  logic [1:0]  rd_chan;
  logic [31:0] rd_value;

  int checks = 0;
  int errors = 0;

  // meter model controls and stimulus injection
  logic [3:0]  silent_mask = 4'b0000;
  logic [31:0] val_base    = 32'd1000;
  logic        model_valid = 1'b0;
  logic [31:0] model_value = 32'd0;
  logic        inj_valid   = 1'b0;
  logic [31:0] inj_value   = 32'd0;
  int          mcnt        = 0;
  logic        mfirst      = 1'b1;

  // monitor state
  int          sd_cnt   = 0;
  logic        ena_seen = 1'b0;
  int          q_ch[$];
  logic [31:0] q_val[$];

  assign meas_valid = model_valid | inj_valid;
  assign meas_value = inj_valid ? inj_value : model_value;

  always #5 clk = ~clk;

  freq_meter_scheduler #(
    .CH_NUM(4), .SETTLE_CYCLES(16), .DISCARD_NUM(1), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .chan_mask(chan_mask), .meas_valid(meas_valid), .meas_value(meas_value),
    .mux_sel(mux_sel), .meter_ena(meter_ena), .busy(busy), .res_we(res_we),
    .res_chan(res_chan), .res_value(res_value), .dead(dead),
    .scan_done(scan_done), .rd_chan(rd_chan), .rd_value(rd_value)
  );

  // Meter: every 5 enabled cycles a readout; first after enable is a partial (0x0BAD)
  always @(negedge clk) begin
    model_valid = 1'b0;
    if (!meter_ena) begin
      mcnt   = 0;
      mfirst = 1'b1;
    end else begin
      mcnt++;
      if (mcnt == 5) begin
        mcnt = 0;
        if (!silent_mask[mux_sel]) begin
          model_valid = 1'b1;
          model_value = mfirst ? 32'h0000_0BAD : val_base + 32'(mux_sel);
          mfirst      = 1'b0;
        end
      end
    end
  end

  // Record result strobes and scan completions
  always @(posedge clk) begin
    if (res_we) begin
      q_ch.push_back(int'(res_chan));
      q_val.push_back(res_value);
    end
    if (scan_done) sd_cnt++;
    if (meter_ena) ena_seen = 1'b1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [3:0] mask);
    chan_mask = mask;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_sd(input string tag, input int target);
    int n = 0;
    while (sd_cnt < target && n < 3000) begin
      step();
      n++;
    end
    chk(tag, 32'(sd_cnt), 32'(target));
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] ch, input logic [31:0] exp);
    rd_chan = ch;
    step();
    chk(tag, rd_value, exp);
  endtask

  task automatic clear_q();
    q_ch.delete();
    q_val.delete();
  endtask

  task automatic chk_res(input string tag, input int idx, input int ch, input logic [31:0] v);
    logic [31:0] oc;
    logic [31:0] ov;
    oc = (idx < q_ch.size()) ? 32'(q_ch[idx]) : 32'hFFFF_FFFF;
    ov = (idx < q_val.size()) ? q_val[idx] : 32'hFFFF_FFFF;
    chk({tag, "_chan"}, oc, 32'(ch));
    chk({tag, "_value"}, ov, v);
  endtask

  initial begin
    int sd0;
    int n;
    rst        = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    chan_mask  = 4'b0000;
    rd_chan    = 2'd0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // reset state
    chk("rst_mux_sel",   32'(mux_sel),   32'd0);
    chk("rst_meter_ena", 32'(meter_ena), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_res_we",    32'(res_we),    32'd0);
    chk("rst_res_value", res_value,      32'd0);
    chk("rst_dead",      32'(dead),      32'd0);
    chk("rst_scan_done", 32'(scan_done), 32'd0);
    chk("rst_rd_value",  rd_value,       32'd0);

    // 1: full scan, first readout per channel discarded
    clear_q();
    val_base = 32'd1000;
    pulse_start(4'b1111);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_sd("t1_scan_done", 1);
    chk("t1_res_count", 32'(q_ch.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_res("t1_res", i, i, 32'd1000 + 32'(i));
    step();
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_dead", 32'(dead), 32'd0);
    for (int i = 0; i < 4; i++) rd_chk("t1_table", 2'(i), 32'd1000 + 32'(i));

    // 2: partial mask leaves masked-off entries alone
    clear_q();
    val_base = 32'd2000;
    pulse_start(4'b0101);
    wait_sd("t2_scan_done", 2);
    chk("t2_res_count", 32'(q_ch.size()), 32'd2);
    chk_res("t2_res0", 0, 0, 32'd2000);
    chk_res("t2_res1", 1, 2, 32'd2002);
    rd_chk("t2_table0", 2'd0, 32'd2000);
    rd_chk("t2_table1", 2'd1, 32'd1001);
    rd_chk("t2_table2", 2'd2, 32'd2002);
    rd_chk("t2_table3", 2'd3, 32'd1003);

    // 3: silent channel times out and is marked dead, later recovery clears it
    clear_q();
    val_base    = 32'd3000;
    silent_mask = 4'b0010;
    pulse_start(4'b1111);
    wait_sd("t3_scan_done", 3);
    chk("t3_res_count", 32'(q_ch.size()), 32'd4);
    chk_res("t3_res1", 1, 1, 32'd0);
    chk_res("t3_res2", 2, 2, 32'd3002);
    chk("t3_dead", 32'(dead), 32'b0010);
    rd_chk("t3_table1", 2'd1, 32'd0);
    rd_chk("t3_table3", 2'd3, 32'd3003);
    clear_q();
    silent_mask = 4'b0000;
    val_base    = 32'd4000;
    pulse_start(4'b0010);
    wait_sd("t3b_scan_done", 4);
    chk_res("t3b_res", 0, 1, 32'd4001);
    chk("t3b_dead", 32'(dead), 32'd0);
    rd_chk("t3b_table0", 2'd0, 32'd3000);
    rd_chk("t3b_table1", 2'd1, 32'd4001);

    // 4: continuous mode runs exactly one more scan after it is dropped
    clear_q();
    val_base   = 32'd5000;
    sd0        = sd_cnt;
    continuous = 1'b1;
    pulse_start(4'b1001);
    wait_sd("t4_scan2", sd0 + 2);
    n = 0;
    while (!busy && n < 20) begin
      step();
      n++;
    end
    chk("t4_restart_busy", 32'(busy), 32'd1);
    continuous = 1'b0;
    wait_sd("t4_scan3", sd0 + 3);
    repeat (200) step();
    chk("t4_no_extra_scan", 32'(sd_cnt), 32'(sd0 + 3));
    chk("t4_busy_low", 32'(busy), 32'd0);
    chk("t4_res_count", 32'(q_ch.size()), 32'd6);
    chk_res("t4_res5", 5, 3, 32'd5003);

    // 5: empty mask finishes two cycles after start without touching the meter
    clear_q();
    ena_seen = 1'b0;
    sd0      = sd_cnt;
    pulse_start(4'b0000);
    chk("t5_busy_sel", 32'(busy), 32'd1);
    chk("t5_done_early", 32'(scan_done), 32'd0);
    step();
    chk("t5_done", 32'(scan_done), 32'd1);
    chk("t5_busy_done", 32'(busy), 32'd0);
    step();
    chk("t5_done_pulse", 32'(scan_done), 32'd0);
    repeat (5) step();
    chk("t5_res_count", 32'(q_ch.size()), 32'd0);
    chk("t5_meter_ena_seen", 32'(ena_seen), 32'd0);
    chk("t5_sd_count", 32'(sd_cnt), 32'(sd0 + 1));

    // 6: settle-time strobe ignored, then reset in the middle of ch2 MEASURE
    clear_q();
    val_base    = 32'd6000;
    silent_mask = 4'b0010;
    rd_chan     = 2'd0;
    pulse_start(4'b1111);
    step();
    chk("t6_settle_ena", 32'(meter_ena), 32'd0);
    inj_value = 32'h0000_DEAD;
    inj_valid = 1'b1;
    step();
    inj_valid = 1'b0;
    n = 0;
    while (!(model_valid && mux_sel == 2'd2) && n < 1000) begin
      step();
      n++;
    end
    chk("t6_reached_ch2", 32'(model_valid && mux_sel == 2'd2), 32'd1);
    step();
    chk("t6_res0", q_val.size() > 0 ? q_val[0] : 32'hFFFF_FFFF, 32'd6000);
    chk("t6_rd_before", rd_value, 32'd6000);
    chk("t6_dead_before", 32'(dead), 32'b0010);
    chk("t6_ena_measure", 32'(meter_ena), 32'd1);
    sd0 = sd_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_mux_sel",   32'(mux_sel),   32'd0);
    chk("t6_meter_ena", 32'(meter_ena), 32'd0);
    chk("t6_busy",      32'(busy),      32'd0);
    chk("t6_res_value", res_value,      32'd0);
    chk("t6_res_chan",  32'(res_chan),  32'd0);
    chk("t6_dead",      32'(dead),      32'd0);
    chk("t6_rd_value",  rd_value,       32'd0);
    for (int i = 0; i < 4; i++) rd_chk("t6_table", 2'(i), 32'd0);
    repeat (50) step();
    chk("t6_no_scan_done", 32'(sd_cnt), 32'(sd0));
    chk("t6_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
